doconv_mac_pipe: RTL and testbench



---
 rtl/doconv_mac_pipe.sv | 120 ++++++++++++
 tb/tb_doconv_mac_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doconv_mac_pipe.sv
// doconv_mac_pipe: pipelined signed multiply-accumulate over framed runs,
// with scaled, rounded and optionally saturated per-run results.
module doconv_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 12,
  parameter int acc_WIDTH  = 32,
  parameter int dout_WIDTH = 16,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         first,
  input  logic                         last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         out_valid,
  output logic                         ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int TW = (acc_WIDTH > dout_WIDTH) ? acc_WIDTH + 1
                                               : dout_WIDTH + 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [TW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (TW'(1) << RS) : '0;
  localparam logic signed [dout_WIDTH-1:0] DMAX =
    {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [dout_WIDTH-1:0] DMIN =
    {1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam int L = NUM_STAGE - 1;

  if (acc_WIDTH < PW) begin : g_bad_acc
    $error("doconv_mac_pipe %0d: acc_WIDTH too narrow", ID);
  end
  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
    $error("doconv_mac_pipe %0d: NUM_STAGE out of 1..4", ID);
  end
  if (SHIFT < 0 || SHIFT >= acc_WIDTH) begin : g_bad_shift
    $error("doconv_mac_pipe %0d: SHIFT out of range", ID);
  end

  logic signed [PW-1:0]        prod;
  logic [NUM_STAGE-1:0]        pv;
  logic [NUM_STAGE-1:0]        pf;
  logic [NUM_STAGE-1:0]        pl;
  logic signed [acc_WIDTH-1:0] pp [NUM_STAGE];
  logic signed [acc_WIDTH-1:0] acc;
  logic signed [acc_WIDTH-1:0] base;
  logic signed [acc_WIDTH-1:0] p;
  logic signed [acc_WIDTH-1:0] sum;
  logic                        sticky;
  logic                        add_ovf;
  logic                        sticky_n;
  logic                        inrange;
  logic signed [TW-1:0]        t;
  logic signed [TW-1:0]        ts;
  logic signed [dout_WIDTH-1:0] res;

  assign prod = din0 * din1;

  always_comb begin
    p        = pp[L];
    base     = pf[L] ? '0 : acc;
    sum      = base + p;
    add_ovf  = (base[acc_WIDTH-1] == p[acc_WIDTH-1]) &&
               (sum[acc_WIDTH-1] != base[acc_WIDTH-1]);
    sticky_n = (sticky & ~pf[L]) | add_ovf;
    t        = TW'(sum) + RND;
    ts       = t >>> SHIFT;
    // in range when every bit above the result sign matches it
    inrange  = (&ts[TW-1:dout_WIDTH-1]) | ~(|ts[TW-1:dout_WIDTH-1]);
    res      = ts[dout_WIDTH-1:0];
    if (!inrange && SATURATE != 0)
      res = ts[TW-1] ? DMIN : DMAX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv        <= '0;
      pf        <= '0;
      pl        <= '0;
      for (int i = 0; i < NUM_STAGE; i++)
        pp[i] <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      pv[0] <= in_valid;
      pf[0] <= first;
      pl[0] <= last;
      if (in_valid)
        pp[0] <= acc_WIDTH'(prod);
      for (int i = 1; i < NUM_STAGE; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pl[i] <= pl[i-1];
        pp[i] <= pp[i-1];
      end
      out_valid <= pv[L] & pl[L];
      if (pv[L]) begin
        acc    <= sum;
        sticky <= sticky_n;
        if (pl[L]) begin
          dout <= res;
          ovf  <= sticky_n | ~inrange;
        end
      end
    end
  end

endmodule

// File: tb/tb_doconv_mac_pipe.sv
// tb_doconv_mac_pipe: directed checks of doconv_mac_pipe across
// several parameter sets driven from one shared stimulus.
module tb_doconv_mac_pipe;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  logic in_valid;
  logic first;
  logic last;
  logic signed [15:0] din0;
  logic signed [11:0] din1;

  logic signed [15:0] dout_a, dout_b, dout_c, dout_d, dout_e;
  logic ov_a, ov_b, ov_c, ov_d, ov_e;
  logic ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  doconv_mac_pipe u_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .first(first), .last(last), .din0(din0), .din1(din1),
    .dout(dout_a), .out_valid(ov_a), .ovf(ovf_a)
  );

  doconv_mac_pipe #(.SATURATE(0)) u_b (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .first(first), .last(last), .din0(din0), .din1(din1),
    .dout(dout_b), .out_valid(ov_b), .ovf(ovf_b)
  );

  doconv_mac_pipe #(.SHIFT(4), .ROUND(0)) u_c (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .first(first), .last(last), .din0(din0), .din1(din1),
    .dout(dout_c), .out_valid(ov_c), .ovf(ovf_c)
  );

  doconv_mac_pipe #(.SHIFT(4), .ROUND(1)) u_d (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .first(first), .last(last), .din0(din0), .din1(din1),
    .dout(dout_d), .out_valid(ov_d), .ovf(ovf_d)
  );

  doconv_mac_pipe #(.acc_WIDTH(28)) u_e (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .first(first), .last(last), .din0(din0), .din1(din1),
    .dout(dout_e), .out_valid(ov_e), .ovf(ovf_e)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic l,
                       input int a, input int b);
    in_valid = v;
    first    = f;
    last     = l;
    din0     = 16'(a);
    din1     = 12'(b);
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ce    = 1'b1;
    idle();
    #1;
    checks++;
    if (ov_a !== 1'b0) begin
      errs++; $display("FAIL reset_ov: got %0b want 0", ov_a);
    end
    checks++;
    if (dout_a !== 16'sd0) begin
      errs++; $display("FAIL reset_dout: got %0d want 0", dout_a);
    end
    checks++;
    if (ovf_a !== 1'b0) begin
      errs++; $display("FAIL reset_ovf: got %0b want 0", ovf_a);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (ov_e !== 1'b0 || dout_e !== 16'sd0) begin
      errs++; $display("FAIL reset_e: got ov=%0b dout=%0d want 0 0",
                       ov_e, dout_e);
    end
  endtask

  task automatic test_single;
    drive(1'b1, 1'b1, 1'b1, 100, -3);
    tick();
    idle();
    checks++;
    if (ov_a !== 1'b0) begin
      errs++; $display("FAIL single_early1: got %0b want 0", ov_a);
    end
    tick();
    checks++;
    if (ov_a !== 1'b0) begin
      errs++; $display("FAIL single_early2: got %0b want 0", ov_a);
    end
    tick();
    checks++;
    if (ov_a !== 1'b1) begin
      errs++; $display("FAIL single_ov: got %0b want 1", ov_a);
    end
    checks++;
    if (dout_a !== -16'sd300) begin
      errs++; $display("FAIL single_dout: got %0d want -300", dout_a);
    end
    checks++;
    if (ovf_a !== 1'b0) begin
      errs++; $display("FAIL single_ovf: got %0b want 0", ovf_a);
    end
    tick();
    checks++;
    if (ov_a !== 1'b0 || dout_a !== -16'sd300) begin
      errs++; $display("FAIL single_hold: got ov=%0b dout=%0d want 0 -300",
                       ov_a, dout_a);
    end
  endtask

  task automatic test_saturate;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k == 0, k == 3, 1000, 1000);
      tick();
    end
    idle();
    tick();
    tick();
    checks++;
    if (ov_a !== 1'b1 || dout_a !== 16'sd32767 || ovf_a !== 1'b1) begin
      errs++; $display("FAIL sat_on: got ov=%0b dout=%0d ovf=%0b want 1 32767 1",
                       ov_a, dout_a, ovf_a);
    end
    checks++;
    if (ov_b !== 1'b1 || dout_b !== 16'sd2304 || ovf_b !== 1'b1) begin
      errs++; $display("FAIL sat_off: got ov=%0b dout=%0d ovf=%0b want 1 2304 1",
                       ov_b, dout_b, ovf_b);
    end
    tick();
  endtask

  task automatic test_shift;
    drive(1'b1, 1'b1, 1'b1, 8, 3);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (ov_c !== 1'b1 || dout_c !== 16'sd1 || ovf_c !== 1'b0) begin
      errs++; $display("FAIL shift_pos_trunc: got ov=%0b dout=%0d ovf=%0b want 1 1 0",
                       ov_c, dout_c, ovf_c);
    end
    checks++;
    if (ov_d !== 1'b1 || dout_d !== 16'sd2) begin
      errs++; $display("FAIL shift_pos_round: got ov=%0b dout=%0d want 1 2",
                       ov_d, dout_d);
    end
    drive(1'b1, 1'b1, 1'b1, -8, 3);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (ov_c !== 1'b1 || dout_c !== -16'sd2) begin
      errs++; $display("FAIL shift_neg_trunc: got ov=%0b dout=%0d want 1 -2",
                       ov_c, dout_c);
    end
    checks++;
    if (ov_d !== 1'b1 || dout_d !== -16'sd1) begin
      errs++; $display("FAIL shift_neg_round: got ov=%0b dout=%0d want 1 -1",
                       ov_d, dout_d);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 1'b0, 2, 3);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4, 5);
    tick();
    drive(1'b1, 1'b1, 1'b1, -7, 7);
    tick();
    idle();
    tick();
    checks++;
    if (ov_a !== 1'b1 || dout_a !== 16'sd26) begin
      errs++; $display("FAIL b2b_first: got ov=%0b dout=%0d want 1 26",
                       ov_a, dout_a);
    end
    tick();
    checks++;
    if (ov_a !== 1'b1 || dout_a !== -16'sd49) begin
      errs++; $display("FAIL b2b_second: got ov=%0b dout=%0d want 1 -49",
                       ov_a, dout_a);
    end
    tick();
    checks++;
    if (ov_a !== 1'b0) begin
      errs++; $display("FAIL b2b_drop: got %0b want 0", ov_a);
    end
  endtask

  task automatic test_ce;
    int cnt = 0;
    int at = -1;
    logic held = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ce = (i % 2 == 0);
      if (i == 0)      drive(1'b1, 1'b1, 1'b0, 1, 1);
      else if (i == 2) drive(1'b1, 1'b0, 1'b0, 1, 1);
      else if (i == 4) drive(1'b1, 1'b0, 1'b1, 1, 1);
      else             idle();
      if (i == 9) held = ov_a;
      if (ce && ov_a) begin
        cnt++;
        if (at < 0) at = i;
      end
      tick();
    end
    ce = 1'b1;
    checks++;
    if (cnt != 1) begin
      errs++; $display("FAIL ce_count: got %0d want 1", cnt);
    end
    checks++;
    if (at != 10) begin
      errs++; $display("FAIL ce_latency: got cycle %0d want 10", at);
    end
    checks++;
    if (held !== 1'b1) begin
      errs++; $display("FAIL ce_hold: got %0b want 1", held);
    end
    checks++;
    if (dout_a !== 16'sd3) begin
      errs++; $display("FAIL ce_dout: got %0d want 3", dout_a);
    end
  endtask

  task automatic test_reset_midrun;
    int cnt = 0;
    drive(1'b1, 1'b1, 1'b0, 1000, 1000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1000, 1000);
    tick();
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (ov_a !== 1'b0 || dout_a !== 16'sd0 || ovf_a !== 1'b0) begin
      errs++; $display("FAIL midrst_clear: got ov=%0b dout=%0d ovf=%0b want 0 0 0",
                       ov_a, dout_a, ovf_a);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ov_a) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errs++; $display("FAIL midrst_stale_out: got %0d pulses want 0", cnt);
    end
    drive(1'b1, 1'b0, 1'b1, 5, 5);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (ov_a !== 1'b1 || dout_a !== 16'sd25) begin
      errs++; $display("FAIL midrst_acc: got ov=%0b dout=%0d want 1 25",
                       ov_a, dout_a);
    end
    drive(1'b1, 1'b1, 1'b1, 5, 5);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (ov_a !== 1'b1 || dout_a !== 16'sd25 || ovf_a !== 1'b0) begin
      errs++; $display("FAIL midrst_fresh: got ov=%0b dout=%0d ovf=%0b want 1 25 0",
                       ov_a, dout_a, ovf_a);
    end
    tick();
  endtask

  task automatic test_wrap;
    drive(1'b1, 1'b1, 1'b0, -32768, -2048);
    tick();
    drive(1'b1, 1'b0, 1'b1, -32768, -2048);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (ov_e !== 1'b1 || dout_e !== -16'sd32768 || ovf_e !== 1'b1) begin
      errs++; $display("FAIL wrap_e: got ov=%0b dout=%0d ovf=%0b want 1 -32768 1",
                       ov_e, dout_e, ovf_e);
    end
    checks++;
    if (dout_a !== 16'sd32767 || ovf_a !== 1'b1) begin
      errs++; $display("FAIL wrap_a: got dout=%0d ovf=%0b want 32767 1",
                       dout_a, ovf_a);
    end
    drive(1'b1, 1'b1, 1'b1, 1, 1);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (ov_e !== 1'b1 || dout_e !== 16'sd1 || ovf_e !== 1'b0) begin
      errs++; $display("FAIL wrap_sticky_clr: got ov=%0b dout=%0d ovf=%0b want 1 1 0",
                       ov_e, dout_e, ovf_e);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_shift();
    test_back_to_back();
    test_ce();
    test_reset_midrun();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
